// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one L2/memory bus port among NUM_REQ requesters.
// One transaction in flight at a time; it completes on mem_ready or, optionally, on timeout.
module mem_bus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int LINE_W      = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_load,
  input  logic [NUM_REQ-1:0]         req_store,
  input  logic [NUM_REQ*64-1:0]      req_addr,
  input  logic [NUM_REQ*LINE_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         resp_ready,
  output logic [NUM_REQ-1:0]         resp_error,
  output logic [LINE_W-1:0]          resp_rdata,
  output logic                       mem_req_load,
  output logic                       mem_req_store,
  output logic [63:0]                mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  input  logic [LINE_W-1:0]          mem_rdata,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [ID_W-1:0]     rr_ptr_r, rr_ptr_nxt_s;
  logic [ID_W-1:0]     grant_id_r, grant_id_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                mem_req_load_r, load_nxt_s;
  logic                mem_req_store_r, store_nxt_s;
  logic [63:0]         mem_addr_r, addr_nxt_s;
  logic [LINE_W-1:0]   mem_wdata_r, wdata_nxt_s;
  logic [NUM_REQ-1:0]  active_s;
  logic [NUM_REQ-1:0]  owner_onehot_s;
  logic                win_found_s;
  logic [ID_W-1:0]     win_idx_s;
  logic                timeout_s;
  logic [NUM_REQ-1:0]  resp_ready_s, resp_error_s;
  logic [LINE_W-1:0]   resp_rdata_s;

  // (base + off) mod NUM_REQ, used for the rotating search and pointer advance
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
    int sum_v;
    sum_v = int'(base) + off;
    return ID_W'(sum_v % NUM_REQ);
  endfunction

  assign active_s       = req_load | req_store;
  assign owner_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
  assign timeout_s      = (TIMEOUT_CYC != 0) && (cnt_r == CNT_W'(TO_LAST));

  // Round-robin search: first active requester starting at rr_ptr_r
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      win_idx_s   = (!win_found_s && active_s[rr_index(rr_ptr_r, i)]) ? rr_index(rr_ptr_r, i) : win_idx_s;
      win_found_s = win_found_s | active_s[rr_index(rr_ptr_r, i)];
    end
  end

  // Next-state and response logic for the IDLE/BUSY transaction FSM
  always_comb begin
    state_nxt_s    = state_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    grant_id_nxt_s = grant_id_r;
    cnt_nxt_s      = cnt_r;
    load_nxt_s     = mem_req_load_r;
    store_nxt_s    = mem_req_store_r;
    addr_nxt_s     = mem_addr_r;
    wdata_nxt_s    = mem_wdata_r;
    resp_ready_s   = {NUM_REQ{1'b0}};
    resp_error_s   = {NUM_REQ{1'b0}};
    resp_rdata_s   = {LINE_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nxt_s    = ST_BUSY;
          grant_id_nxt_s = win_idx_s;
          cnt_nxt_s      = {CNT_W{1'b0}};
          // store has priority when a requester raises both
          store_nxt_s    = req_store[win_idx_s];
          load_nxt_s     = req_load[win_idx_s] & ~req_store[win_idx_s];
          addr_nxt_s     = req_addr[int'(win_idx_s)*64 +: 64];
          wdata_nxt_s    = req_wdata[int'(win_idx_s)*LINE_W +: LINE_W];
        end else begin
          cnt_nxt_s      = {CNT_W{1'b0}};
        end
      end
      ST_BUSY: begin
        if (mem_ready || timeout_s) begin
          resp_ready_s = owner_onehot_s;
          resp_error_s = mem_ready ? {NUM_REQ{1'b0}} : owner_onehot_s;
          resp_rdata_s = mem_ready ? mem_rdata : {LINE_W{1'b0}};
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = rr_index(grant_id_r, 1);
          cnt_nxt_s    = {CNT_W{1'b0}};
          load_nxt_s   = 1'b0;
          store_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s    = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        load_nxt_s  = 1'b0;
        store_nxt_s = 1'b0;
      end
    endcase
  end

  // State and downstream request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      rr_ptr_r        <= {ID_W{1'b0}};
      grant_id_r      <= {ID_W{1'b0}};
      cnt_r           <= {CNT_W{1'b0}};
      mem_req_load_r  <= 1'b0;
      mem_req_store_r <= 1'b0;
      mem_addr_r      <= 64'h0;
      mem_wdata_r     <= {LINE_W{1'b0}};
    end else begin
      state_r         <= state_nxt_s;
      rr_ptr_r        <= rr_ptr_nxt_s;
      grant_id_r      <= grant_id_nxt_s;
      cnt_r           <= cnt_nxt_s;
      mem_req_load_r  <= load_nxt_s;
      mem_req_store_r <= store_nxt_s;
      mem_addr_r      <= addr_nxt_s;
      mem_wdata_r     <= wdata_nxt_s;
    end
  end

  assign resp_ready    = resp_ready_s;
  assign resp_error    = resp_error_s;
  assign resp_rdata    = resp_rdata_s;
  assign mem_req_load  = mem_req_load_r;
  assign mem_req_store = mem_req_store_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign grant_valid   = (state_r == ST_BUSY);
  assign grant_id      = grant_id_r;

endmodule
